icache_mshr_txreq_arb: RTL and testbench

Round-robin arbiter that shares the single downstream txreq channel among all icache MSHR entries. Each entry raises a request with its miss payload; the arbiter grants one entry per cycle, registers the winning payload into an output stage toward the downstream interface, and limits outstanding downstream requests with a credit counter replenished by downstream responses. It sits between the MSHR entry array and the icache downstream request port.

---
 rtl/icache_mshr_txreq_arb.sv | 129 ++++++++++++
 tb/tb_icache_mshr_txreq_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mshr_txreq_arb.sv
// rtl/icache_mshr_txreq_arb.sv - round-robin arbiter of icache MSHR entries onto the downstream txreq channel
//
// Optional feature macro: ICACHE_TXREQ_CREDIT_EN (credit counter, credit-gated grants, credit_err).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_vld        per-entry request valid
//   req_pld        per-entry payload, entry i at [i*PLD_WIDTH +: PLD_WIDTH]
//   req_rdy        one-hot combinational grant
//   out_vld        downstream txreq valid (registered)
//   out_rdy        downstream txreq ready
//   out_pld        registered winning payload
//   out_entry_idx  entry owning out_pld
//   rsp_vld        downstream response, returns one credit
//   credit_cnt     credits currently available
//   credit_err     sticky: response returned while all credits were already home
module icache_mshr_txreq_arb #(
    parameter int ENTRY_NUM  = 8,
    parameter int PLD_WIDTH  = 42,
    parameter int CREDIT_NUM = 4,
    parameter int IDX_WIDTH  = $clog2(ENTRY_NUM),
    parameter int CNT_WIDTH  = $clog2(CREDIT_NUM + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ENTRY_NUM-1:0]           req_vld,
    input  logic [ENTRY_NUM*PLD_WIDTH-1:0] req_pld,
    output logic [ENTRY_NUM-1:0]           req_rdy,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [PLD_WIDTH-1:0]           out_pld,
    output logic [IDX_WIDTH-1:0]           out_entry_idx,
    input  logic                           rsp_vld,
    output logic [CNT_WIDTH-1:0]           credit_cnt,
    output logic                           credit_err
);

    logic                 stage_accept;
    logic                 credit_ok;
    logic                 grant_en;
    logic                 found;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [IDX_WIDTH-1:0] cand;
    logic [PLD_WIDTH-1:0] grant_pld;

    // The stage can take a new payload when empty or when it is being drained this cycle.
    assign stage_accept = !out_vld || out_rdy;

    // Search upward from rr_ptr; ENTRY_NUM is a power of two so the index add wraps for free.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            cand = rr_ptr + IDX_WIDTH'(k);
            if (!found && req_vld[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_pld = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (grant_idx == IDX_WIDTH'(i)) begin
                grant_pld = req_pld[i*PLD_WIDTH +: PLD_WIDTH];
            end
        end
    end

    // Gated by rst_n so no requester sees a handshake while reset is held.
    assign grant_en = rst_n && found && stage_accept && credit_ok;
    assign req_rdy  = grant_en ? (ENTRY_NUM'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld       <= 1'b0;
            out_pld       <= '0;
            out_entry_idx <= '0;
            rr_ptr        <= '0;
        end else if (grant_en) begin
            out_vld       <= 1'b1;
            out_pld       <= grant_pld;
            out_entry_idx <= grant_idx;
            rr_ptr        <= grant_idx + 1'b1;
        end else if (out_rdy) begin
            // Drain without reload: payload and index keep their last value.
            out_vld <= 1'b0;
        end
    end

`ifdef ICACHE_TXREQ_CREDIT_EN
    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDIT_NUM);

    logic [CNT_WIDTH-1:0] credit_q;
    logic                 err_q;

    // Uses the registered count, so a credit returned this cycle only helps next cycle.
    assign credit_ok = (credit_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= CREDIT_MAX;
            err_q    <= 1'b0;
        end else if (grant_en && !rsp_vld) begin
            credit_q <= credit_q - 1'b1;
        end else if (!grant_en && rsp_vld) begin
            if (credit_q == CREDIT_MAX) begin
                err_q <= 1'b1;
            end else begin
                credit_q <= credit_q + 1'b1;
            end
        end
    end

    assign credit_cnt = credit_q;
    assign credit_err = err_q;
`else
    logic unused_rsp_vld;

    assign credit_ok      = 1'b1;
    assign credit_cnt     = CNT_WIDTH'(CREDIT_NUM);
    assign credit_err     = 1'b0;
    assign unused_rsp_vld = rsp_vld;
`endif

endmodule

// File: tb/tb_icache_mshr_txreq_arb.sv
// tb/tb_icache_mshr_txreq_arb.sv - self-checking bench for icache_mshr_txreq_arb
module tb_icache_mshr_txreq_arb;

    localparam int N   = 8;
    localparam int PW  = 42;
    localparam int CN  = 4;
    localparam int IW  = 3;
    localparam int CW  = 3;
`ifdef ICACHE_TXREQ_CREDIT_EN
    localparam bit CREDIT_EN = 1'b1;
`else
    localparam bit CREDIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_vld;
    logic [N*PW-1:0] req_pld;
    logic [N-1:0]  req_rdy;
    logic          out_vld;
    logic          out_rdy;
    logic [PW-1:0] out_pld;
    logic [IW-1:0] out_entry_idx;
    logic          rsp_vld;
    logic [CW-1:0] credit_cnt;
    logic          credit_err;

    icache_mshr_txreq_arb #(
        .ENTRY_NUM (N),
        .PLD_WIDTH (PW),
        .CREDIT_NUM(CN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_pld      (req_pld),
        .req_rdy      (req_rdy),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_pld      (out_pld),
        .out_entry_idx(out_entry_idx),
        .rsp_vld      (rsp_vld),
        .credit_cnt   (credit_cnt),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stage contents, fairness pointer, credit pool.
    logic          m_vld;
    logic [PW-1:0] m_pld;
    int            m_idx;
    int            m_rr;
    int            m_cred;
    logic          m_err;
    logic [N-1:0]  g_last;
    bit            hold;
    bit            auto_rsp;

    // Oldest-since-last-winner: lowest requester at or after the pointer, else lowest overall.
    function automatic int pick(input logic [N-1:0] v, input int rr);
        int best = -1;
        for (int i = rr; i < N; i++) if (v[i] && best < 0) best = i;
        for (int i = 0; i < rr; i++) if (v[i] && best < 0) best = i;
        return best;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        g = -1;
        exp_rdy = '0;
        if (!rst_n) begin
            m_vld = 1'b0; m_pld = '0; m_idx = 0; m_rr = 0; m_cred = CN; m_err = 1'b0;
        end else if ((!m_vld || out_rdy) && (!CREDIT_EN || m_cred > 0)) begin
            g = pick(req_vld, m_rr);
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        g_last = exp_rdy;

        chk("req_rdy", req_rdy, exp_rdy);
        chk("out_vld", out_vld, m_vld);
        chk("out_pld", out_pld, m_pld);
        chk("out_entry_idx", out_entry_idx, m_idx);
        chk("credit_cnt", credit_cnt, m_cred);
        chk("credit_err", credit_err, m_err);

        if (rst_n) begin
            if (g >= 0) begin
                m_vld = 1'b1;
                m_pld = req_pld[g*PW +: PW];
                m_idx = g;
                m_rr  = (g + 1) % N;
            end else if (m_vld && out_rdy) begin
                m_vld = 1'b0;
            end
            if (CREDIT_EN) begin
                if (g >= 0 && !rsp_vld) m_cred = m_cred - 1;
                else if (g < 0 && rsp_vld) begin
                    if (m_cred == CN) m_err = 1'b1;
                    else m_cred = m_cred + 1;
                end
            end
        end
    end

    // Requesters drop after their handshake unless told to keep re-requesting.
    task automatic step();
        @(posedge clk);
        #1;
        if (!hold) req_vld = req_vld & ~g_last;
        if (auto_rsp) rsp_vld = (m_cred < CN);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_vld = '0; rsp_vld = 1'b0; out_rdy = 1'b0;
        hold = 1'b0; auto_rsp = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic new_payloads();
        for (int i = 0; i < N; i++) req_pld[i*PW +: PW] = {$urandom, $urandom};
    endtask

    logic [N-1:0] seq[$];
    logic [N-1:0] exp_seq[9];
    logic [PW-1:0] saved;

    initial begin
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        req_pld = '0;
        do_reset();
        chk("rst req_rdy", req_rdy, 0);
        chk("rst out_vld", out_vld, 0);
        chk("rst out_pld", out_pld, 0);
        chk("rst out_entry_idx", out_entry_idx, 0);
        chk("rst credit_cnt", credit_cnt, CN);
        chk("rst credit_err", credit_err, 0);

        // Single request, then pointer check via next winner.
        new_payloads();
        req_vld = 8'b0000_0100; out_rdy = 1'b1;
        #1 chk("single req_rdy", req_rdy, 8'b0000_0100);
        step();
        chk("single out_vld", out_vld, 1);
        chk("single idx", out_entry_idx, 2);
        chk("single pld", out_pld, req_pld[2*PW +: PW]);
        req_vld = 8'b0001_0010;
        #1 chk("rr after 2", req_rdy, 8'b0001_0000);
        step(); step(); step(); step();

        // Fairness with continuous requests.
        do_reset();
        new_payloads();
        req_vld = '1; hold = 1'b1; auto_rsp = 1'b1; out_rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1 seq.push_back(req_rdy);
            step();
        end
        for (int k = 0; k < 9; k++) chk("rr order", seq[k], exp_seq[k]);
        hold = 1'b0; req_vld = '0;
        repeat (4) step();
        auto_rsp = 1'b0; rsp_vld = 1'b0;

        // Backpressure.
        do_reset();
        new_payloads();
        out_rdy = 1'b1; req_vld = 8'b0000_0001;
        step();
        out_rdy = 1'b0; req_vld = 8'b0010_0010;
        saved = out_pld;
        #1 chk("bp req_rdy", req_rdy, 0);
        step(); step();
        chk("bp pld stable", out_pld, saved);
        chk("bp idx", out_entry_idx, 0);
        out_rdy = 1'b1;
        #1 chk("bp release grant", req_rdy, 8'b0000_0010);
        step();
        chk("b2b out_vld", out_vld, 1);
        chk("b2b idx", out_entry_idx, 1);
        step();
        chk("b2b idx5", out_entry_idx, 5);
        step(); step();
        rsp_vld = 1'b0;

        // Credit exhaustion.
        do_reset();
        new_payloads();
        out_rdy = 1'b1; req_vld = 8'b0001_1111;
        step(); step(); step(); step();
`ifdef ICACHE_TXREQ_CREDIT_EN
        chk("exh credit", credit_cnt, 0);
        chk("exh held", req_rdy, 0);
        rsp_vld = 1'b1;
        #1 chk("exh same cycle", req_rdy, 0);
        step();
        rsp_vld = 1'b0;
        chk("exh credit1", credit_cnt, 1);
        #1 chk("exh 5th grant", req_rdy, 8'b0001_0000);
        step();
        chk("exh 5th idx", out_entry_idx, 4);
        chk("exh credit0", credit_cnt, 0);
`endif
        step(); step();

        // Simultaneous grant and response; overflow error.
        do_reset();
        new_payloads();
        out_rdy = 1'b1; req_vld = 8'b0000_0011;
        step(); step();
        req_vld = 8'b0000_0100; rsp_vld = 1'b1;
        step();
`ifdef ICACHE_TXREQ_CREDIT_EN
        chk("simul credit", credit_cnt, 2);
`endif
        step(); step(); step();
        rsp_vld = 1'b0;
        step();
`ifdef ICACHE_TXREQ_CREDIT_EN
        chk("ovf credit", credit_cnt, 4);
        chk("ovf err", credit_err, 1);
`endif

        // Reset mid-operation.
        do_reset();
        new_payloads();
        out_rdy = 1'b1; req_vld = 8'b0000_0111;
        step(); step(); step();
        out_rdy = 1'b0;
        chk("pre-rst out_vld", out_vld, 1);
`ifdef ICACHE_TXREQ_CREDIT_EN
        chk("pre-rst credit", credit_cnt, 1);
`endif
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_vld", out_vld, 0);
        chk("mid-rst credit", credit_cnt, CN);
        chk("mid-rst err", credit_err, 0);
        step();
        rst_n = 1'b1; req_vld = 8'b1000_0001;
        #1 chk("post-rst ptr0", req_rdy, 8'b0000_0001);
        out_rdy = 1'b1;
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
